soc_mem_arbiter: RTL and testbench

- Parametrised shared-memory block: one 2^ADDR_W x DATA_W memory, one user port, NPORT CPU ports.
- Arbitrates the single write port each cycle:
  - user port has absolute priority;
  - CPU ports are served round-robin;
  - losing ports receive a per-port stall.
- Adds a hardware memory-clear sequence (state machine) not present in the previous generation.
- Sits at SoC top between the user port and NPORT cpu instances; each cpu's hlt is driven from its o_p_stall bit.

---
 rtl/soc_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_soc_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_mem_arbiter.sv
// Shared memory with user-priority, round-robin CPU write arbitration and a clear FSM; SOC_MEM_ARB_COLLISION_CNT_EN adds a collision counter.
// Reads are combinational and writes commit at the next edge; losing or halted CPU ports see o_p_stall and must hold their request.
module soc_mem_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int NPORT  = 2,
   parameter int TIMER  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      hlt,
   input  logic                      i_clr,
   input  logic [ADDR_W-1:0]         i_addr,
   input  logic [DATA_W-1:0]         i_data,
   input  logic                      i_we,
   output logic [DATA_W-1:0]         o_data,
   output logic                      o_busy,
   input  logic [NPORT*ADDR_W-1:0]   i_p_iaddr,
   input  logic [NPORT*ADDR_W-1:0]   i_p_daddr,
   input  logic [NPORT*DATA_W-1:0]   i_p_wdata,
   input  logic [NPORT-1:0]          i_p_we,
   output logic [NPORT*DATA_W-1:0]   o_p_inst,
   output logic [NPORT*DATA_W-1:0]   o_p_rdata,
`ifdef SOC_MEM_ARB_COLLISION_CNT_EN
   input  logic                      i_coll_clr,
   output logic [15:0]               o_coll_cnt,
`endif
   output logic [NPORT-1:0]          o_p_stall
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

   if (NPORT < 1 || NPORT > 8 || TIMER < 1) begin : g_param_chk
      $error("soc_mem_arbiter: NPORT must be 1..8 and TIMER positive");
   end

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   logic [PTR_W-1:0]  rr_ptr;
   logic [ADDR_W-1:0] clr_addr;

   (* mem_timer_loop = TIMER *) logic [DATA_W-1:0] mem [DEPTH];

   logic [NPORT-1:0] req;
   logic [NPORT-1:0] grant;
   logic             cpu_win;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] cand;
   logic [PTR_W-1:0] next_ptr;

   // Scan NPORT candidates starting at rr_ptr; the first requester wins.
   always_comb begin
      req     = i_p_we & ~{NPORT{hlt}};
      grant   = '0;
      cpu_win = 1'b0;
      win_idx = rr_ptr;
      cand    = rr_ptr;
      if (state == IDLE && !i_we) begin
         for (int i = 0; i < NPORT; i++) begin
            if (!cpu_win && req[cand]) begin
               cpu_win = 1'b1;
               win_idx = cand;
            end
            cand = (int'(cand) == NPORT - 1) ? '0 : cand + 1'b1;
         end
         if (cpu_win) grant[win_idx] = 1'b1;
      end
   end

   assign next_ptr = (int'(win_idx) == NPORT - 1) ? '0 : win_idx + 1'b1;

   always_comb begin
      if (!rst || state == CLEAR) o_p_stall = '1;
      else                        o_p_stall = {NPORT{hlt}} | (i_p_we & ~grant);
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR)
         mem[clr_addr] <= '0;
      else if (i_we)
         mem[i_addr] <= i_data;
      else if (cpu_win)
         mem[i_p_daddr[int'(win_idx)*ADDR_W +: ADDR_W]] <= i_p_wdata[int'(win_idx)*DATA_W +: DATA_W];
   end

   assign o_data = mem[i_addr];

   for (genvar p = 0; p < NPORT; p++) begin : g_rd
      assign o_p_inst[p*DATA_W +: DATA_W]  = mem[i_p_iaddr[p*ADDR_W +: ADDR_W]];
      assign o_p_rdata[p*DATA_W +: DATA_W] = mem[i_p_daddr[p*ADDR_W +: ADDR_W]];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         clr_addr <= '0;
         o_busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_win) rr_ptr <= next_ptr;
               if (i_clr) begin
                  state  <= CLEAR;
                  o_busy <= 1'b1;
               end
            end
            CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (&clr_addr) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SOC_MEM_ARB_COLLISION_CNT_EN
   logic coll_evt;

   // In IDLE an unhalted requester without a grant is exactly a stalled one.
   assign coll_evt = (state == IDLE) && !hlt && |(i_p_we & ~grant);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         o_coll_cnt <= '0;
      else if (i_coll_clr)
         o_coll_cnt <= '0;
      else if (coll_evt && !(&o_coll_cnt))
         o_coll_cnt <= o_coll_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Scoreboard bench for soc_mem_arbiter: a queue-based reference model predicts each cycle's outputs, a negedge monitor compares.
// Directed scenarios cover reset, round-robin, user priority, halt, clear and reset mid-clear, followed by randomized traffic.
module tb_soc_mem_arbiter;
   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int NP    = 2;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, hlt, i_clr, i_we;
   logic [AW-1:0]    i_addr;
   logic [DW-1:0]    i_data, o_data;
   logic             o_busy;
   logic [NP*AW-1:0] i_p_iaddr, i_p_daddr;
   logic [NP*DW-1:0] i_p_wdata, o_p_inst, o_p_rdata;
   logic [NP-1:0]    i_p_we, o_p_stall;
`ifdef SOC_MEM_ARB_COLLISION_CNT_EN
   logic             i_coll_clr;
   logic [15:0]      o_coll_cnt;
`endif

   soc_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NPORT(NP), .TIMER(16)) dut (
      .clk(clk), .rst(rst), .hlt(hlt), .i_clr(i_clr),
      .i_addr(i_addr), .i_data(i_data), .i_we(i_we),
      .o_data(o_data), .o_busy(o_busy),
      .i_p_iaddr(i_p_iaddr), .i_p_daddr(i_p_daddr), .i_p_wdata(i_p_wdata), .i_p_we(i_p_we),
      .o_p_inst(o_p_inst), .o_p_rdata(o_p_rdata),
`ifdef SOC_MEM_ARB_COLLISION_CNT_EN
      .i_coll_clr(i_coll_clr), .o_coll_cnt(o_coll_cnt),
`endif
      .o_p_stall(o_p_stall)
   );

   typedef struct packed {
      logic [NP-1:0]    stall;
      logic             busy;
      logic [DW-1:0]    odata;
      logic             odata_k;
      logic [NP*DW-1:0] inst;
      logic [NP-1:0]    inst_k;
      logic [NP*DW-1:0] rdata;
      logic [NP-1:0]    rdata_k;
      logic [15:0]      cnt;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_known [DEPTH];
   int            m_rr = 0;
   bit            m_clearing = 0;
   int            m_clr = 0;
   logic [15:0]   m_cnt = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic int winner();
      if (i_we) return -1;
      for (int i = 0; i < NP; i++) begin
         int k = (m_rr + i) % NP;
         if (i_p_we[k] && !hlt) return k;
      end
      return -1;
   endfunction

   function automatic exp_t make_exp();
      exp_t e;
      int   w;
      logic [AW-1:0] a;
      w = winner();
      e = '0;
      for (int k = 0; k < NP; k++) begin
         if (!rst || m_clearing) e.stall[k] = 1'b1;
         else e.stall[k] = hlt || (i_p_we[k] && (i_we || w != k));
         a = i_p_iaddr[k*AW +: AW];
         e.inst[k*DW +: DW] = m_mem[a];
         e.inst_k[k] = m_known[a];
         a = i_p_daddr[k*AW +: AW];
         e.rdata[k*DW +: DW] = m_mem[a];
         e.rdata_k[k] = m_known[a];
      end
      e.busy    = m_clearing;
      e.odata   = m_mem[i_addr];
      e.odata_k = m_known[i_addr];
      e.cnt     = m_cnt;
      return e;
   endfunction

   task automatic commit();
      int w;
      bit evt;
      logic [AW-1:0] a;
      w   = winner();
      evt = 0;
      for (int k = 0; k < NP; k++)
         if (i_p_we[k] && (i_we || w != k)) evt = 1;
      evt = evt && !hlt && !m_clearing;
      if (m_clearing) begin
         m_mem[m_clr] = '0;
         m_known[m_clr] = 1;
         m_clr++;
         if (m_clr == DEPTH) begin
            m_clr = 0;
            m_clearing = 0;
         end
      end else begin
         if (i_we) begin
            m_mem[i_addr] = i_data;
            m_known[i_addr] = 1;
         end else if (w >= 0) begin
            a = i_p_daddr[w*AW +: AW];
            m_mem[a] = i_p_wdata[w*DW +: DW];
            m_known[a] = 1;
            if (rst) m_rr = (w + 1) % NP;
         end
         if (rst && i_clr) begin
            m_clearing = 1;
            m_clr = 0;
         end
      end
`ifdef SOC_MEM_ARB_COLLISION_CNT_EN
      if (!rst) m_cnt = '0;
      else if (i_coll_clr) m_cnt = '0;
      else if (evt && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`else
      if (evt) m_cnt = m_cnt;
`endif
   endtask

   task automatic set_rst(input logic v);
      rst = v;
      if (!v) begin
         m_rr = 0;
         m_clearing = 0;
         m_clr = 0;
         m_cnt = '0;
      end
   endtask

   task automatic tick();
      q.push_back(make_exp());
      @(posedge clk);
      commit();
      #1;
   endtask

   task automatic idle_inputs();
      hlt = 0; i_clr = 0; i_we = 0; i_addr = '0; i_data = '0;
      i_p_iaddr = '0; i_p_daddr = '0; i_p_wdata = '0; i_p_we = '0;
`ifdef SOC_MEM_ARB_COLLISION_CNT_EN
      i_coll_clr = 0;
`endif
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall", o_p_stall, e.stall);
            chk("busy", o_busy, e.busy);
            if (e.odata_k) chk("o_data", o_data, e.odata);
            for (int k = 0; k < NP; k++) begin
               if (e.inst_k[k])  chk("o_p_inst", o_p_inst[k*DW +: DW], e.inst[k*DW +: DW]);
               if (e.rdata_k[k]) chk("o_p_rdata", o_p_rdata[k*DW +: DW], e.rdata[k*DW +: DW]);
            end
`ifdef SOC_MEM_ARB_COLLISION_CNT_EN
            chk("coll_cnt", o_coll_cnt, e.cnt);
`endif
         end
      end
   end

   initial begin : stim
      int n;
      idle_inputs();
      set_rst(0);
      @(posedge clk); #1;
      chk("rst_busy", o_busy, 0);
      tick(); tick();
      set_rst(1);

      // Preload then full clear, with an ignored user write mid-clear
      i_we = 1; i_addr = 8'h00; i_data = 8'h12; tick();
      i_addr = 8'hFF; i_data = 8'h34; tick();
      i_we = 0; i_addr = 8'h00; #1 chk("pre_00", o_data, 8'h12);
      i_clr = 1; tick(); i_clr = 0;
      n = 0;
      for (int c = 0; c < 300; c++) begin
         if (!o_busy) break;
         n++;
         i_we = (c == 50); i_addr = 8'hFF; i_data = 8'hEE;
         tick();
      end
      i_we = 0;
      chk("clr_len", n, 256);
      i_addr = 8'h00; #1 chk("clr_00", o_data, 8'h00);
      i_addr = 8'hFF; #1 chk("clr_ff", o_data, 8'h00);
      chk("clr_busy_done", o_busy, 0);

      // Round robin
      i_p_we = 2'b11; i_p_daddr = {8'h20, 8'h10}; i_p_wdata = {8'hB2, 8'hA1};
      #1 chk("rr_c1_stall", o_p_stall, 2'b10); tick();
      i_p_we = 2'b10; #1 chk("rr_c2_stall", o_p_stall, 2'b00); tick();
      i_p_we = 2'b00; #1;
      chk("rr_m10", o_p_rdata[7:0], 8'hA1);
      chk("rr_m20", o_p_rdata[15:8], 8'hB2);
      tick();

      // User priority over a same-address CPU write
      i_we = 1; i_addr = 8'h30; i_data = 8'h55;
      i_p_we = 2'b01; i_p_daddr = {8'h31, 8'h30}; i_p_wdata = {8'h66, 8'h77};
      #1 chk("up_stall0", o_p_stall[0], 1'b1); tick();
      i_we = 0; #1 chk("up_mem55", o_data, 8'h55); tick();
      i_p_we = 2'b00; #1 chk("up_mem77", o_data, 8'h77);
      i_p_we = 2'b11; #1 chk("up_rr_stall", o_p_stall, 2'b01); tick();
      i_p_we = 2'b00;

      // Halt
      hlt = 1; i_p_we = 2'b01; i_p_daddr = {8'h41, 8'h40}; i_p_wdata = {8'h88, 8'h99}; i_addr = 8'h40;
      #1 chk("hlt_stall", o_p_stall, 2'b11); tick();
      hlt = 0; i_p_we = 2'b00; #1 chk("hlt_mem40", o_data, 8'h00);
      i_p_we = 2'b11; #1 chk("hlt_rr_stall", o_p_stall, 2'b10); tick();
      i_p_we = 2'b00;

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         hlt       = ($urandom_range(0, 7) == 0);
         i_we      = ($urandom_range(0, 3) == 0);
         i_clr     = ($urandom_range(0, 149) == 0);
         i_addr    = AW'($urandom);
         i_data    = DW'($urandom);
         i_p_iaddr = (NP*AW)'($urandom);
         i_p_daddr = (NP*AW)'($urandom);
         i_p_wdata = (NP*DW)'($urandom);
         i_p_we    = NP'($urandom);
`ifdef SOC_MEM_ARB_COLLISION_CNT_EN
         i_coll_clr = ($urandom_range(0, 49) == 0);
`endif
         tick();
      end
      idle_inputs();
      for (int c = 0; c < 300 && m_clearing; c++) tick();

      // Reset in the middle of a clear
      i_clr = 1; tick(); i_clr = 0;
      for (int c = 1; c < 100; c++) tick();
      set_rst(0);
      #1 chk("mc_busy_async", o_busy, 0);
      tick();
      set_rst(1);
      i_p_we = 2'b10; i_p_daddr = {8'h50, 8'h00}; i_p_wdata = {8'hC3, 8'h00};
      #1 chk("mc_stall", o_p_stall, 2'b00); tick();
      i_p_we = 2'b00; i_addr = 8'h50;
      #1 chk("mc_mem50", o_data, 8'hC3);
      chk("mc_busy_idle", o_busy, 0);
      tick();

`ifdef SOC_MEM_ARB_COLLISION_CNT_EN
      i_coll_clr = 1; tick(); i_coll_clr = 0;
      i_p_we = 2'b11;
      repeat (5) tick();
      chk("cnt_5", o_coll_cnt, 16'd5);
      i_coll_clr = 1; tick(); i_coll_clr = 0;
      chk("cnt_clr", o_coll_cnt, 16'd0);
      force dut.o_coll_cnt = 16'hFFFF;
      m_cnt = 16'hFFFF;
      tick();
      release dut.o_coll_cnt;
      chk("cnt_sat", o_coll_cnt, 16'hFFFF);
      tick();
      chk("cnt_sat2", o_coll_cnt, 16'hFFFF);
      i_p_we = 2'b00;
`endif

      idle_inputs();
      tick(); tick();
      @(negedge clk); #1;
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
